prog_loader: RTL and testbench

- Byte-stream boot loader that sits directly upstream of the processor's instruction memory.
- Receives a framed program over a valid/ready byte interface and assembles big-endian 32-bit instructions.
- Writes each instruction into i_mem at consecutive addresses from 0.
- Holds the core in reset until the frame checksum verifies, then releases it.

---
 rtl/proc_pkg.sv | 20 ++
 rtl/prog_loader_if.sv | 29 ++
 rtl/inst_assembler.sv | 56 +++++
 rtl/prog_loader.sv | 157 +++++++++++++++
 tb/tb_prog_loader.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the program loader slice.
//   INST_W         : instruction width (4 bytes, big-endian assembly)
//   SYNC_BYTE      : frame start marker
//   loader_state_t : loader FSM state encoding
package proc_pkg;

  localparam int         INST_W    = 32;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    SYNC,
    COUNT,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream receive channel plus instruction-memory write port.
//   rx_data/rx_valid/rx_ready : valid/ready byte stream into the loader
//   imem_addr/imem_data/imem_we : single-cycle write strobe into i_mem
// Modports:
//   master : byte sender / i_mem side
//   slave  : the loader
interface prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 32
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_data;
  logic              imem_we;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_addr, imem_data, imem_we
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_addr, imem_data, imem_we
  );

endinterface

// File: rtl/inst_assembler.sv
// Datapath for the loader: big-endian instruction shift register, byte
// index within the current instruction and running XOR checksum.
//   clk, reset : clock, async active-low reset
//   byte_in    : accepted byte
//   chk_clr    : zero the checksum (frame start)
//   chk_en     : fold byte_in into the checksum
//   shift_en   : shift byte_in into the low end of word, advance index
//   idx_clr    : restart byte index at 0
//   word       : assembled instruction (first byte ends in the MSBs)
//   chk        : current checksum
//   last_byte  : index points at the final byte of an instruction
module inst_assembler
  import proc_pkg::*;
#(
  parameter int INST_W = proc_pkg::INST_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        byte_in,
  input  logic              chk_clr,
  input  logic              chk_en,
  input  logic              shift_en,
  input  logic              idx_clr,
  output logic [INST_W-1:0] word,
  output logic [7:0]        chk,
  output logic              last_byte
);

  localparam int NB    = INST_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word <= '0;
      chk  <= '0;
      idx  <= '0;
    end else begin
      if (chk_clr)     chk <= '0;
      else if (chk_en) chk <= chk ^ byte_in;

      // NB is a power of two, so the index wraps back to 0 after the
      // last byte without an explicit compare.
      if (idx_clr)       idx <= '0;
      else if (shift_en) idx <= idx + IDX_W'(1);

      // Shifting in from the right leaves the first byte in the MSBs
      // once all NB bytes have arrived.
      if (shift_en) word <= {word[INST_W-9:0], byte_in};
    end
  end

  assign last_byte = (idx == IDX_W'(NB - 1));

endmodule

// File: rtl/prog_loader.sv
// Boot loader in front of the instruction memory. Receives a framed
// program (SYNC, COUNT=N, N*4 instruction bytes MSB first, CHK) and writes
// each instruction to i_mem from address 0. The core is held in reset
// until a frame's XOR checksum (over COUNT and payload) verifies.
//   clk, reset : clock, async active-low reset
//   bus        : slave side of prog_loader_if (byte stream in, i_mem out)
//   core_reset : active-high reset to the core, low only once loaded
//   done       : program loaded and verified
//   error      : frame rejected (bad count or checksum)
//   inst_count : instructions written in the current or last frame
module prog_loader
  import proc_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter int         INST_W    = proc_pkg::INST_W,
  parameter logic [7:0] SYNC_BYTE = proc_pkg::SYNC_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  prog_loader_if.slave      bus,
  output logic              core_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] inst_count
);

  // Largest N that keeps the last written address at 2**ADDR_W-2.
  localparam int N_MAX = (1 << ADDR_W) - 1;

  loader_state_t     state;
  logic [7:0]        n_r;
  logic              rx_ready_r;
  logic [ADDR_W-1:0] addr_r;
  logic              we_r;

  logic              accept;
  logic              is_sync;
  logic              n_bad;
  logic              chk_clr, chk_en, shift_en, idx_clr;
  logic [INST_W-1:0] word;
  logic [7:0]        chk;
  logic              last_byte;

  assign accept  = bus.rx_valid & rx_ready_r;
  assign is_sync = (bus.rx_data == SYNC_BYTE);
  assign n_bad   = (bus.rx_data == 8'd0) || (32'(bus.rx_data) > N_MAX);

  // Marker is only honoured where a new frame may start; inside
  // COUNT/DATA/CHECK the same value is plain payload.
  assign chk_clr  = accept & is_sync &
                    ((state == SYNC) | (state == DONE) | (state == ERR));
  assign chk_en   = accept & ((state == COUNT) | (state == DATA));
  assign shift_en = accept & (state == DATA);
  assign idx_clr  = accept & (state == COUNT);

  inst_assembler #(.INST_W(INST_W)) u_asm (
    .clk       (clk),
    .reset     (reset),
    .byte_in   (bus.rx_data),
    .chk_clr   (chk_clr),
    .chk_en    (chk_en),
    .shift_en  (shift_en),
    .idx_clr   (idx_clr),
    .word      (word),
    .chk       (chk),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SYNC;
      n_r        <= '0;
      rx_ready_r <= 1'b1;
      addr_r     <= '0;
      we_r       <= 1'b0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      inst_count <= '0;
    end else begin
      case (state)
        SYNC: begin
          if (accept && is_sync) state <= COUNT;
        end

        COUNT: begin
          if (accept) begin
            n_r        <= bus.rx_data;
            addr_r     <= '0;
            inst_count <= '0;
            if (n_bad) begin
              state <= ERR;
              error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          // Word is complete on this edge; the strobe and the stall
          // both take effect for the following single WRITE cycle.
          if (accept && last_byte) begin
            state      <= WRITE;
            we_r       <= 1'b1;
            rx_ready_r <= 1'b0;
          end
        end

        WRITE: begin
          we_r       <= 1'b0;
          rx_ready_r <= 1'b1;
          addr_r     <= addr_r + ADDR_W'(1);
          inst_count <= inst_count + ADDR_W'(1);
          if (32'(inst_count) + 1 == 32'(n_r)) state <= CHECK;
          else                                 state <= DATA;
        end

        CHECK: begin
          if (accept) begin
            if (bus.rx_data == chk) begin
              state      <= DONE;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end

        DONE: begin
          if (accept && is_sync) begin
            state      <= COUNT;
            done       <= 1'b0;
            core_reset <= 1'b1;
          end
        end

        ERR: begin
          if (accept && is_sync) begin
            state <= COUNT;
            error <= 1'b0;
          end
        end

        default: state <= SYNC;
      endcase
    end
  end

  assign bus.rx_ready  = rx_ready_r;
  assign bus.imem_addr = addr_r;
  assign bus.imem_data = word;
  assign bus.imem_we   = we_r;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  import proc_pkg::*;

  typedef struct packed {
    logic [15:0][7:0] bytes;
    int               len;
    int               pre;
    int               gap_max;
    int               nw;
    logic [1:0][31:0] words;
    logic             exp_done;
    logic             exp_err;
    logic [7:0]       exp_cnt;
  } vec_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       core_reset, done, error;
  logic [7:0] inst_count;

  prog_loader_if #(.ADDR_W(8), .INST_W(32)) bus ();

  prog_loader #(.ADDR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .core_reset (core_reset),
    .done       (done),
    .error      (error),
    .inst_count (inst_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   fails  = 0;
  wr_t  sb[$];
  logic tb_last4 = 1'b0;
  logic we_due   = 1'b0;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: monitor at the falling edge, return at posedge+1.
  task automatic tick(output bit acc);
    wr_t w;
    @(negedge clk);
    acc = bus.rx_valid && bus.rx_ready;
    if (!reset) begin
      we_due = 1'b0;
    end else begin
      if (bus.imem_we) begin
        check("we_latency", {63'd0, we_due}, 64'd1);
        check("ready_low_in_write", {63'd0, bus.rx_ready}, 64'd0);
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                   bus.imem_addr, bus.imem_data);
        end else begin
          w = sb.pop_front();
          check("imem_addr", {56'd0, bus.imem_addr}, {56'd0, w.addr});
          check("imem_data", {32'd0, bus.imem_data}, {32'd0, w.data});
        end
      end else if (we_due) begin
        check("we_missing", {63'd0, bus.imem_we}, 64'd1);
      end
      we_due = acc && tb_last4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last4, input int gap);
    bit acc;
    int n;
    tb_last4     = last4;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 20);
    check("byte_accepted", {63'd0, acc}, 64'd1);
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      tb_last4     = 1'b0;
      repeat (gap) tick(acc);
    end
  endtask

  function automatic vec_t mk(input logic [127:0] s, input int len, input int pre,
                              input int gap, input int nw, input logic [31:0] w0,
                              input logic [31:0] w1, input logic d, input logic e,
                              input logic [7:0] c);
    vec_t r;
    r = '0;
    for (int i = 0; i < len; i++) r.bytes[i] = s[8*(len-1-i) +: 8];
    r.len = len; r.pre = pre; r.gap_max = gap; r.nw = nw;
    r.words[0] = w0; r.words[1] = w1;
    r.exp_done = d; r.exp_err = e; r.exp_cnt = c;
    return r;
  endfunction

  task automatic send_frame(input int v, input string tag);
    int   pos;
    logic l4;
    wr_t  w;
    for (int k = 0; k < vecs[v].nw; k++) begin
      w.addr = 8'(k);
      w.data = vecs[v].words[k];
      sb.push_back(w);
    end
    for (int i = 0; i < vecs[v].len; i++) begin
      pos = i - vecs[v].pre;
      l4  = (pos >= 2) && (pos < 2 + 4 * vecs[v].nw) && ((pos - 2) % 4 == 3);
      send_byte(vecs[v].bytes[i], l4,
                (vecs[v].gap_max > 0) ? int'($urandom_range(0, vecs[v].gap_max)) : 0);
    end
    bus.rx_valid = 1'b0;
    tb_last4     = 1'b0;
    check({tag, "_done"},       {63'd0, done},       {63'd0, vecs[v].exp_done});
    check({tag, "_error"},      {63'd0, error},      {63'd0, vecs[v].exp_err});
    check({tag, "_core_reset"}, {63'd0, core_reset}, {63'd0, ~vecs[v].exp_done});
    check({tag, "_inst_count"}, {56'd0, inst_count}, {56'd0, vecs[v].exp_cnt});
    check({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    vecs[0] = mk({8'hA5, 8'h02, 32'h20010005, 32'h8C020000, 8'hA8}, 11, 0, 0, 2,
                 32'h20010005, 32'h8C020000, 1'b1, 1'b0, 8'd2);
    vecs[1] = mk({8'hA5, 8'h02, 32'h20010005, 32'h8C020000, 8'h00}, 11, 0, 0, 2,
                 32'h20010005, 32'h8C020000, 1'b0, 1'b1, 8'd2);
    vecs[2] = vecs[0];
    vecs[3] = mk({8'h11, 8'hFF, 8'hA5, 8'h02, 32'h20010005, 32'h8C020000, 8'hA8}, 13, 2, 5, 2,
                 32'h20010005, 32'h8C020000, 1'b1, 1'b0, 8'd2);
    vecs[4] = mk({8'hA5, 8'h00}, 2, 0, 0, 0, 32'd0, 32'd0, 1'b0, 1'b1, 8'd0);
    vecs[5] = mk({8'hA5, 8'h01, 32'hA5A5A5A5, 8'h01}, 7, 0, 0, 1,
                 32'hA5A5A5A5, 32'd0, 1'b1, 1'b0, 8'd1);

    reset        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Async reset mid-frame: get into DATA, then pull reset between edges.
    send_byte(8'hA5, 1'b0, 0);
    send_byte(8'h02, 1'b0, 0);
    send_byte(8'h20, 1'b0, 0);
    bus.rx_valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("rst_rx_ready",   {63'd0, bus.rx_ready},  64'd1);
    check("rst_imem_addr",  {56'd0, bus.imem_addr}, 64'd0);
    check("rst_imem_data",  {32'd0, bus.imem_data}, 64'd0);
    check("rst_imem_we",    {63'd0, bus.imem_we},   64'd0);
    check("rst_core_reset", {63'd0, core_reset},    64'd1);
    check("rst_done",       {63'd0, done},          64'd0);
    check("rst_error",      {63'd0, error},         64'd0);
    check("rst_inst_count", {56'd0, inst_count},    64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int v = 0; v < 6; v++) send_frame(v, $sformatf("vec%0d", v));

    // Restart from DONE: marker drops done and re-asserts core_reset at once.
    send_byte(8'hA5, 1'b0, 0);
    check("restart_done",       {63'd0, done},       64'd0);
    check("restart_core_reset", {63'd0, core_reset}, 64'd1);

    // Reset right after the 6th byte of a good frame: no write must follow.
    send_byte(8'h02, 1'b0, 0);
    send_byte(8'h20, 1'b0, 0);
    send_byte(8'h01, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h05, 1'b1, 0);
    bus.rx_valid = 1'b0;
    tb_last4     = 1'b0;
    reset        = 1'b0;
    repeat (2) tick(acc);
    check("midrst_core_reset", {63'd0, core_reset},  64'd1);
    check("midrst_imem_we",    {63'd0, bus.imem_we}, 64'd0);
    check("midrst_inst_count", {56'd0, inst_count},  64'd0);
    reset = 1'b1;
    repeat (5) tick(acc);
    check("midrst_idle_core_reset", {63'd0, core_reset}, 64'd1);
    send_byte(8'h01, 1'b0, 0);
    bus.rx_valid = 1'b0;
    check("midrst_junk_done", {63'd0, done}, 64'd0);
    send_frame(0, "post_rst");
    repeat (3) tick(acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
